// File: rtl/switch_bounce_pkg.sv
// Shared types and LFSR constants for the switch bounce emulator.
package switch_bounce_pkg;

  localparam int LFSR_W = 16;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 16'hB400;

  typedef enum logic {IDLE, BOUNCE} state_t;

  // Galois right-shift step; a nonzero state never maps to zero.
  function automatic logic [LFSR_W-1:0] lfsr_next(input logic [LFSR_W-1:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_MASK : '0);
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Galois LFSR that steps only when asked, so segment draws are reproducible.
module lfsr16
  import switch_bounce_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED = 16'hACE1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              advance,
  output logic [LFSR_W-1:0] state
);

  always_ff @(posedge clk) begin
    if (rst)          state <= SEED;
    else if (advance) state <= lfsr_next(state);
  end

endmodule

// File: rtl/switch_bounce_gen.sv
// Drives a bouncy switch line: random-length toggles for a fixed window after
// each commanded level change, then settles to the commanded level.
module switch_bounce_gen
  import switch_bounce_pkg::*;
#(
  parameter int          BOUNCE_CLKS   = 125000,
  parameter int          SEG_MIN_CLKS  = 64,
  parameter int          SEG_RAND_BITS = 10,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1,
  parameter logic        RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic i_level,
  input  logic i_enable,
  output logic o_switch,
  output logic o_busy,
  output logic o_settled
);

  localparam int WIN_W = $clog2(BOUNCE_CLKS);
  localparam int SEG_W = $clog2(SEG_MIN_CLKS + 2**SEG_RAND_BITS);

  state_t             state;
  logic               target;
  logic [WIN_W-1:0]   win_cnt;
  logic [SEG_W-1:0]   seg_cnt;
  logic [SEG_W-1:0]   seg_len;
  logic [LFSR_W-1:0]  lfsr;
  logic               retrig;
  logic               tog;
  logic               lfsr_unused;

  assign retrig  = i_enable && (i_level != target);
  assign tog     = i_enable && (state == BOUNCE) && (win_cnt != '0) && (seg_cnt == '0);
  assign seg_len = SEG_W'(SEG_MIN_CLKS) + SEG_W'(lfsr[SEG_RAND_BITS-1:0]);
  assign lfsr_unused = ^lfsr;

  // Every seg_len load consumes one LFSR step.
  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk     (clk),
    .rst     (rst),
    .advance (retrig || tog),
    .state   (lfsr)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      o_switch  <= RESET_LEVEL;
      target    <= RESET_LEVEL;
      o_busy    <= 1'b0;
      o_settled <= 1'b0;
      win_cnt   <= '0;
      seg_cnt   <= '0;
    end else begin
      o_settled <= 1'b0;
      if (!i_enable) begin
        o_switch <= i_level;
        target   <= i_level;
        state    <= IDLE;
        o_busy   <= 1'b0;
      end else if (retrig) begin
        target   <= i_level;
        o_switch <= i_level;
        win_cnt  <= WIN_W'(BOUNCE_CLKS - 1);
        seg_cnt  <= seg_len;
        state    <= BOUNCE;
        o_busy   <= 1'b1;
      end else if (state == BOUNCE) begin
        if (win_cnt == '0) begin
          o_switch  <= target;
          o_settled <= 1'b1;
          state     <= IDLE;
          o_busy    <= 1'b0;
        end else begin
          // The window keeps counting through toggles so it ends exactly
          // BOUNCE_CLKS cycles after the last trigger.
          win_cnt <= win_cnt - 1'b1;
          if (seg_cnt == '0) begin
            o_switch <= ~o_switch;
            seg_cnt  <= seg_len;
          end else begin
            seg_cnt <= seg_cnt - 1'b1;
          end
        end
      end
    end
  end

endmodule
